// File: rtl/simmem_pkg.sv
// Shared defaults and slot record type for the simulated-memory release scheduler.
package simmem_pkg;

    localparam int IDWidth    = 4;
    localparam int NumSlots   = 16;
    localparam int DelayWidth = 8;
    localparam int SeqWidth   = $clog2(NumSlots) + 1;

    typedef struct packed {
        logic                  valid;
        logic [IDWidth-1:0]    id;
        logic [DelayWidth-1:0] counter;
        logic [SeqWidth-1:0]   seq;
    } slot_t;

endpackage

// File: rtl/simmem_release_slot.sv
// One delay slot: holds an entry's ID, countdown and per-ID sequence number,
// and reports whether it is the expired head of its ID.
module simmem_release_slot #(
    parameter int IDWidth    = simmem_pkg::IDWidth,
    parameter int NumSlots   = simmem_pkg::NumSlots,
    parameter int DelayWidth = simmem_pkg::DelayWidth,
    parameter int SeqWidth   = $clog2(NumSlots) + 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                alloc,
    input  logic [IDWidth-1:0]                  alloc_id,
    input  logic [DelayWidth-1:0]               alloc_cycles,
    input  logic [SeqWidth-1:0]                 alloc_seq,
    input  logic [2**IDWidth-1:0][SeqWidth-1:0] rel_seq,
    input  logic                                release_valid,
    input  logic [IDWidth-1:0]                  release_id,
    output logic                                valid,
    output logic [IDWidth-1:0]                  id,
    output logic                                expired_head
);
    import simmem_pkg::*;

    logic [DelayWidth-1:0] counter;
    logic [SeqWidth-1:0]   seq;
    logic                  head;
    logic                  hit;

    // The head of an ID is the entry whose sequence matches that ID's release pointer.
    assign head         = valid && (seq == rel_seq[id]);
    assign expired_head = head && (counter == '0);
    assign hit          = expired_head && release_valid && (release_id == id);

    // Allocation loads the entry; otherwise count down and drop on release.
    // Allocation only targets free slots and release only hits valid ones, so they never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            id      <= '0;
            counter <= '0;
            seq     <= '0;
        end else if (alloc) begin
            valid   <= 1'b1;
            id      <= alloc_id;
            counter <= alloc_cycles;
            seq     <= alloc_seq;
        end else begin
            if (hit) begin
                valid <= 1'b0;
            end
            if (valid && (counter != '0)) begin
                counter <= counter - DelayWidth'(1);
            end
        end
    end

endmodule

// File: rtl/simmem_release_scheduler.sv
// Per-ID release scheduler: imposes a latency on each accepted request and
// enables the response bank per ID in issue order once the latency has elapsed.
module simmem_release_scheduler #(
    parameter int IDWidth    = simmem_pkg::IDWidth,
    parameter int NumSlots   = simmem_pkg::NumSlots,
    parameter int DelayWidth = simmem_pkg::DelayWidth
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       delay_valid_i,
    output logic                       delay_ready_o,
    input  logic [IDWidth-1:0]         delay_id_i,
    input  logic [DelayWidth-1:0]      delay_cycles_i,
    output logic [2**IDWidth-1:0]      release_en_o,
    input  logic                       released_valid_i,
    input  logic [IDWidth-1:0]         released_id_i,
    output logic [$clog2(NumSlots):0]  occupancy_o
);
    import simmem_pkg::*;

    localparam int NumIds  = 2**IDWidth;
    localparam int SeqW    = $clog2(NumSlots) + 1;
    localparam int SlotIdx = (NumSlots > 1) ? $clog2(NumSlots) : 1;

    logic [NumSlots-1:0]         slot_valid;
    logic [NumSlots-1:0]         slot_exp;
    logic [NumSlots-1:0]         slot_alloc;
    logic [IDWidth-1:0]          slot_id [NumSlots];
    logic [NumIds-1:0][SeqW-1:0] iss_seq;
    logic [NumIds-1:0][SeqW-1:0] rel_seq;
    logic [SlotIdx-1:0]          free_idx;
    logic                        accept;
    logic                        release_ok;

    assign delay_ready_o = ~&slot_valid;
    assign accept        = delay_valid_i && delay_ready_o;
    assign release_ok    = released_valid_i && release_en_o[released_id_i];

    // Priority encoder: pick the lowest-index free slot.
    always_comb begin
        free_idx = '0;
        for (int s = NumSlots - 1; s >= 0; s--) begin
            if (!slot_valid[s]) begin
                free_idx = SlotIdx'(s);
            end
        end
    end

    // One-hot allocate strobe into the chosen slot.
    always_comb begin
        slot_alloc           = '0;
        slot_alloc[free_idx] = accept;
    end

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        simmem_release_slot #(
            .IDWidth    (IDWidth),
            .NumSlots   (NumSlots),
            .DelayWidth (DelayWidth),
            .SeqWidth   (SeqW)
        ) u_slot (
            .clk           (clk_i),
            .rst_n         (rst_ni),
            .alloc         (slot_alloc[g]),
            .alloc_id      (delay_id_i),
            .alloc_cycles  (delay_cycles_i),
            .alloc_seq     (iss_seq[delay_id_i]),
            .rel_seq       (rel_seq),
            .release_valid (released_valid_i),
            .release_id    (released_id_i),
            .valid         (slot_valid[g]),
            .id            (slot_id[g]),
            .expired_head  (slot_exp[g])
        );
    end

    // Per-ID issue and release pointers; accept and release advance independently.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            iss_seq <= '0;
            rel_seq <= '0;
        end else begin
            if (accept) begin
                iss_seq[delay_id_i] <= iss_seq[delay_id_i] + SeqW'(1);
            end
            if (release_ok) begin
                rel_seq[released_id_i] <= rel_seq[released_id_i] + SeqW'(1);
            end
        end
    end

    // OR each slot's expired-head flag into the bit of its ID.
    always_comb begin
        release_en_o = '0;
        for (int s = 0; s < NumSlots; s++) begin
            if (slot_exp[s]) begin
                release_en_o[slot_id[s]] = 1'b1;
            end
        end
    end

    // Occupancy is the population count of valid slots.
    always_comb begin
        occupancy_o = '0;
        for (int s = 0; s < NumSlots; s++) begin
            occupancy_o = occupancy_o + SeqW'(slot_valid[s]);
        end
    end

    // The bank must only report a release for an ID whose enable is set.
    release_needs_enable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        released_valid_i |-> release_en_o[released_id_i]);

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Directed bench for the release scheduler with hand-computed expectations.
module tb_simmem_release_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        delay_valid;
    logic        delay_ready;
    logic [3:0]  delay_id;
    logic [7:0]  delay_cycles;
    logic [15:0] release_en;
    logic        released_valid;
    logic [3:0]  released_id;
    logic [4:0]  occupancy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc0     = 0;
    logic found;

    always #5 clk = ~clk;

    simmem_release_scheduler dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .delay_valid_i    (delay_valid),
        .delay_ready_o    (delay_ready),
        .delay_id_i       (delay_id),
        .delay_cycles_i   (delay_cycles),
        .release_en_o     (release_en),
        .released_valid_i (released_valid),
        .released_id_i    (released_id),
        .occupancy_o      (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic request(input logic [3:0] id, input logic [7:0] d);
        delay_valid  = 1'b1;
        delay_id     = id;
        delay_cycles = d;
    endtask

    task automatic release_id(input logic [3:0] id);
        released_valid = 1'b1;
        released_id    = id;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        delay_valid    = 1'b0;
        delay_id       = '0;
        delay_cycles   = '0;
        released_valid = 1'b0;
        released_id    = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
        check("rst_ready", 32'(delay_ready), 32'd1);
        check("rst_en",    32'(release_en),  32'h0);
        check("rst_occ",   32'(occupancy),   32'd0);

        // Single request ID 3, D=5 accepted in cycle c: enable from c+6.
        request(4'd3, 8'd5);
        step(1);
        delay_valid = 1'b0;
        check("t1_occ_acc", 32'(occupancy),  32'd1);
        check("t1_en_c1",   32'(release_en), 32'h0);
        step(4);
        check("t1_en_c5",   32'(release_en), 32'h0);
        step(1);
        check("t1_en_c6",   32'(release_en), 32'h0008);
        step(2);
        check("t1_en_c8",   32'(release_en), 32'h0008);
        release_id(4'd3);
        step(1);
        released_valid = 1'b0;
        check("t1_en_rel",  32'(release_en), 32'h0);
        check("t1_occ_rel", 32'(occupancy),  32'd0);

        // ID 2: D=10 then D=0; second entry waits for the first.
        request(4'd2, 8'd10);
        step(1);
        request(4'd2, 8'd0);
        step(1);
        delay_valid = 1'b0;
        check("t2_occ",     32'(occupancy),  32'd2);
        check("t2_en_c2",   32'(release_en), 32'h0);
        step(8);
        check("t2_en_c10",  32'(release_en), 32'h0);
        step(1);
        check("t2_en_c11",  32'(release_en), 32'h0004);
        release_id(4'd2);
        step(1);
        released_valid = 1'b0;
        check("t2_en_c12",  32'(release_en), 32'h0004);
        check("t2_occ_c12", 32'(occupancy),  32'd1);
        release_id(4'd2);
        step(1);
        released_valid = 1'b0;
        check("t2_en_end",  32'(release_en), 32'h0);
        check("t2_occ_end", 32'(occupancy),  32'd0);

        // Fill all 16 slots with D=255, one per ID, then stall a further request.
        for (int i = 0; i < 16; i++) begin
            request(4'(i), 8'd255);
            step(1);
            if (i == 0) acc0 = cyc;
        end
        check("t3_full_ready", 32'(delay_ready), 32'd0);
        check("t3_full_occ",   32'(occupancy),   32'd16);
        request(4'd7, 8'd3);
        step(2);
        check("t3_stall_occ",  32'(occupancy),   32'd16);
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (release_en[0]) found = 1'b1;
            else step(1);
        end
        check("t3_expired",    32'(found),       32'd1);
        check("t3_latency",    32'(cyc - acc0),  32'd255);
        check("t3_en_first",   32'(release_en),  32'h0001);
        release_id(4'd0);
        step(1);
        released_valid = 1'b0;
        check("t3_ready_back", 32'(delay_ready), 32'd1);
        check("t3_occ_free",   32'(occupancy),   32'd15);
        check("t3_en_next",    32'(release_en),  32'h0002);
        step(1);
        delay_valid = 1'b0;
        check("t3_occ_refill", 32'(occupancy),   32'd16);
        check("t3_ready_full", 32'(delay_ready), 32'd0);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("t3_rst_occ",    32'(occupancy),   32'd0);

        // Same-cycle accept and release on ID 5.
        request(4'd5, 8'd0);
        step(1);
        delay_valid = 1'b0;
        check("t4_en_first",   32'(release_en), 32'h0020);
        check("t4_occ_first",  32'(occupancy),  32'd1);
        request(4'd5, 8'd0);
        release_id(4'd5);
        step(1);
        delay_valid    = 1'b0;
        released_valid = 1'b0;
        check("t4_occ_both",   32'(occupancy),  32'd1);
        check("t4_en_both",    32'(release_en), 32'h0020);
        step(1);
        check("t4_en_hold",    32'(release_en), 32'h0020);
        release_id(4'd5);
        step(1);
        released_valid = 1'b0;
        check("t4_en_end",     32'(release_en), 32'h0);
        check("t4_occ_end",    32'(occupancy),  32'd0);

        // Eight pending entries, then a one-edge reset.
        for (int i = 0; i < 8; i++) begin
            request(4'(i), (i < 4) ? 8'd0 : 8'd255);
            step(1);
        end
        delay_valid = 1'b0;
        check("t5_occ",        32'(occupancy),   32'd8);
        check("t5_en",         32'(release_en),  32'h000F);
        rst_n = 1'b0;
        step(1);
        check("t5_rst_en",     32'(release_en),  32'h0);
        check("t5_rst_occ",    32'(occupancy),   32'd0);
        check("t5_rst_ready",  32'(delay_ready), 32'd1);
        rst_n = 1'b1;

        // Fresh request after reset: ID 9, D=1.
        request(4'd9, 8'd1);
        step(1);
        delay_valid = 1'b0;
        check("t6_en_c1",      32'(release_en),  32'h0);
        step(1);
        check("t6_en_c2",      32'(release_en),  32'h0200);
        release_id(4'd9);
        step(1);
        released_valid = 1'b0;
        check("t6_en_end",     32'(release_en),  32'h0);
        check("t6_occ_end",    32'(occupancy),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simmem_release_scheduler.md
# simmem_release_scheduler

Per-ID release scheduler that sits directly upstream of the linked-list response bank in the simulated memory controller. Accepts one delay request per AXI transaction (ID plus latency in cycles) and holds it in a slot whose countdown runs until the latency has elapsed. Drives the bank's per-ID release-enable vector, preserving per-ID ordering. Frees the slot when the bank reports that it has emitted the message.

## Interface

Parameters:
- IDWidth, 4, AXI ID width; release vector has 2**IDWidth bits
- NumSlots, 16, outstanding delay entries across all IDs
- DelayWidth, 8, width of requested delay in cycles

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset; synchronous, active-low
- delay_valid_i  in  1  new delay request valid
- delay_ready_o  out  1  a free slot exists
- delay_id_i  in  IDWidth  AXI ID of request
- delay_cycles_i  in  DelayWidth  latency D to impose
- release_en_o  out  2**IDWidth  bit i set: oldest pending entry of ID i has expired
- released_valid_i  in  1  bank emitted one message
- released_id_i  in  IDWidth  ID of emitted message
- occupancy_o  out  $clog2(NumSlots)+1  number of valid slots

## Operation

- Slot state: valid, id, counter[DelayWidth], seq[$clog2(NumSlots)+1].
- Per-ID registers: iss_seq[id] and rel_seq[id], both $clog2(NumSlots)+1 bits, wrapping modulo 2**width. Equality compare is safe because an ID never has more than NumSlots outstanding entries.
- Accept when delay_valid_i && delay_ready_o:
  - Allocate the lowest-index free slot.
  - Load counter=D, id, seq=iss_seq[id].
  - Increment iss_seq[id].
- Countdown: every valid slot with counter!=0 decrements by 1 each cycle. It does not decrement in its allocation cycle. The counter saturates at 0.
- Head of ID i: the valid slot with id==i and seq==rel_seq[i]. At most one such slot exists.
- release_en_o[i] = head of i exists and its counter==0. This is combinational from registered state only.
- Release: on released_valid_i with release_en_o[released_id_i]=1:
  - Clear the head slot's valid bit.
  - Increment rel_seq[released_id_i].
  - If release_en_o for that ID is 0, the pulse is ignored and an assertion fires.
- delay_ready_o = any slot invalid, computed from registered state. A slot freed in a cycle is not allocatable in the same cycle.
- Simultaneous accept and release, including the same ID: both take effect. The iss/rel counters are updated independently.
- Full: delay_ready_o=0; delay_valid_i is held by upstream (valid must not drop without a handshake).
- occupancy_o = popcount of the valid bits.

## Timing

- Reset values: delay_ready_o=1, release_en_o=0, occupancy_o=0.
  - All slots are invalid; all seq registers are 0; counters are 0.
  - A reset asserted mid-operation discards all pending entries; outputs return to reset values in the cycle after the reset edge.
- Latency: a request accepted in cycle t with delay D raises release_en_o[id] from cycle t+1+D, provided it is head by then. D=0 gives assertion in cycle t+1.
- A non-head entry whose counter has reached 0 waits. Its enable rises in the cycle after the edge on which the preceding entry is released.
- After a release edge, release_en_o[id] deasserts in the next cycle unless the next entry for that ID is already expired. If it is, the bit stays high with no bubble.
- Only one accept and one release per cycle.

## Structure

- simmem_pkg holds:
  - IDWidth, DelayWidth and NumSlots defaults
  - typedef struct slot_t {valid, id, counter, seq}
  - localparam SeqWidth = $clog2(NumSlots)+1
- Sub-module simmem_release_slot: one slot's registers, countdown, and head/expired compare against the rel_seq of its ID. It is instantiated NumSlots times.
- The top level contains:
  - the lowest-free-slot priority encoder
  - the per-ID seq registers
  - the OR-reduction into release_en_o

## Test plan

- After reset, with no stimulus: delay_ready_o=1, release_en_o=0, occupancy_o=0.
- Single request ID=3, D=5, accepted cycle 10: release_en_o[3] rises cycle 16. Pulse released ID 3 in cycle 18: bit clears cycle 19, occupancy 1 to 0.
- ID 2 with D=10 then D=0, accepted cycles 0 and 1: release_en_o[2] stays 0 until cycle 11. Release in cycle 11: the bit stays high in cycle 12 for the second entry.
- Fill 16 slots with D=255: delay_ready_o=0 and the next request stalls. Release one expired entry: ready returns the following cycle, and the stalled request is accepted into the freed slot index.
- Same-cycle accept (ID 5, D=0) and release (ID 5, older entry expired): occupancy unchanged. release_en_o[5] stays 1 for the new entry.
- Assert rst_ni=0 for one edge with 8 pending entries: next cycle release_en_o=0, occupancy 0, delay_ready_o=1.
